packet_display_seq: RTL and testbench

- Parametrised successor to the fixed 9-byte packet viewer.
- Sniffs the byte stream leaving the package slicer and captures one framed packet: a header byte with MSB set, payload bytes, and an all-zero terminator.
- Double-buffers the captured frame and replays it one byte at a time on a display output, with a programmable dwell time per byte.
- Sits between the slicer and the board LEDs/debug port.

---
 rtl/packet_display_seq.sv | 147 ++++++++++++++
 tb/tb_packet_display_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_display_seq.sv
// Frame capture and replay viewer: sniffs header/payload/terminator frames from
// the slicer byte stream, double-buffers the last committed frame and cycles
// through its bytes on the display output with a programmable dwell time.
module packet_display_seq #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BYTES = 9,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned DWELL_W   = 26
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               data_valid,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               freeze,
  output logic [DATA_W-1:0]  data_shown,
  output logic [IDX_W-1:0]   byte_idx,
  output logic [IDX_W-1:0]   frame_len,
  output logic               frame_ready,
  output logic               capturing,
  output logic               overflow
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(MAX_BYTES);

  logic [1:0]         state, state_d;
  logic [IDX_W-1:0]   cnt, cnt_d;
  logic [DATA_W-1:0]  cap  [MAX_BYTES];
  logic [DATA_W-1:0]  disp [MAX_BYTES];
  logic [DWELL_W-1:0] dwell_cnt;

  logic               is_zero, is_hdr;
  logic               commit, set_ovf, wr_en;
  logic [IDX_W-1:0]   wr_idx;

  logic [DWELL_W-1:0] dwell_limit;
  logic               expire;
  logic [IDX_W-1:0]   next_idx;
  logic [DATA_W-1:0]  next_byte;

  assign is_zero   = (data_in == '0);
  assign is_hdr    = data_in[DATA_W-1];
  assign capturing = (state == ST_CAPTURE);

  // Capture FSM decode: a valid header byte restarts capture from any state,
  // which covers IDLE start, CAPTURE resync and DISCARD restart alike.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    commit  = 1'b0;
    set_ovf = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cnt;
    if (data_valid) begin
      if (is_hdr) begin
        state_d = ST_CAPTURE;
        cnt_d   = IDX_W'(1);
        wr_en   = 1'b1;
        wr_idx  = '0;
      end else begin
        case (state)
          ST_CAPTURE: begin
            if (is_zero) begin
              commit  = 1'b1;
              state_d = ST_IDLE;
            end else if (cnt == MAX_LEN) begin
              // Buffer full: keep what we have, drop the rest of this frame.
              set_ovf = 1'b1;
              commit  = 1'b1;
              state_d = ST_DISCARD;
            end else begin
              wr_en = 1'b1;
              cnt_d = cnt + IDX_W'(1);
            end
          end
          ST_DISCARD: begin
            if (is_zero) state_d = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Capture state, byte counter, capture buffer and sticky overflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < int'(MAX_BYTES); i++) cap[i] <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (set_ovf) overflow <= 1'b1;
      if (wr_en) begin
        for (int i = 0; i < int'(MAX_BYTES); i++) begin
          if (wr_idx == IDX_W'(i)) cap[i] <= data_in;
        end
      end
    end
  end

  // Dwell expiry and next display position; a dwell of 0 behaves as 1
  always_comb begin
    dwell_limit = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_W'(1);
    expire      = (dwell_cnt >= dwell_limit);
    next_idx    = (byte_idx == frame_len - IDX_W'(1)) ? '0 : byte_idx + IDX_W'(1);
    next_byte   = '0;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (next_idx == IDX_W'(i)) next_byte = disp[i];
    end
  end

  // Display side: commit swaps in the whole frame at once and beats both
  // freeze and dwell expiry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_len   <= '0;
      frame_ready <= 1'b0;
      byte_idx    <= '0;
      data_shown  <= '0;
      dwell_cnt   <= '0;
      for (int i = 0; i < int'(MAX_BYTES); i++) disp[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < int'(MAX_BYTES); i++) disp[i] <= cap[i];
      frame_len   <= cnt;
      frame_ready <= 1'b1;
      byte_idx    <= '0;
      data_shown  <= cap[0];
      dwell_cnt   <= '0;
    end else if (frame_ready && !freeze) begin
      if (expire) begin
        dwell_cnt  <= '0;
        byte_idx   <= next_idx;
        data_shown <= next_byte;
      end else begin
        dwell_cnt <= dwell_cnt + DWELL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_packet_display_seq.sv
// Bench for packet_display_seq: a frame-level reference model predicts the
// outputs after every clock (and on async reset), the stimulus side queues
// those predictions and an independent monitor pops and compares them.
module tb_packet_display_seq;

  localparam int unsigned MB = 9;
  localparam int unsigned WW = 26;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    data_in = '0;
  logic          data_valid = 1'b0;
  logic [WW-1:0] dwell_cycles = '0;
  logic          freeze = 1'b0;
  logic [7:0]    data_shown;
  logic [3:0]    byte_idx;
  logic [3:0]    frame_len;
  logic          frame_ready;
  logic          capturing;
  logic          overflow;

  packet_display_seq #(
    .DATA_W(8), .MAX_BYTES(MB), .IDX_W(4), .DWELL_W(WW)
  ) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .dwell_cycles(dwell_cycles), .freeze(freeze), .data_shown(data_shown),
    .byte_idx(byte_idx), .frame_len(frame_len), .frame_ready(frame_ready),
    .capturing(capturing), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] shown;
    logic [3:0] idx;
    logic [3:0] len;
    logic       ready;
    logic       capt;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: frames as byte queues, display as position + elapsed time
  logic [7:0] m_cur[$];
  logic [7:0] m_disp[$];
  int         m_mode;     // 0 waiting for header, 1 collecting, 2 skipping
  bit         m_have;
  int         m_pos;
  int         m_elapsed;
  bit         m_ovf;
  int         cur_dwell = 4;
  bit         cur_freeze = 1'b0;

  function automatic void model_reset();
    m_cur.delete();
    m_disp.delete();
    m_mode = 0; m_have = 0; m_pos = 0; m_elapsed = 0; m_ovf = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.shown = m_have ? m_disp[m_pos] : 8'h00;
    e.idx   = 4'(m_pos);
    e.len   = 4'(m_disp.size());
    e.ready = m_have;
    e.capt  = (m_mode == 1);
    e.ovf   = m_ovf;
    return e;
  endfunction

  function automatic void model_edge(input logic [7:0] d, input bit v);
    bit commit = 0;
    int lim;
    if (v) begin
      if (d[7]) begin
        m_cur.delete();
        m_cur.push_back(d);
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (d == 8'h00) begin
          commit = 1; m_mode = 0;
        end else if (m_cur.size() == MB) begin
          commit = 1; m_ovf = 1; m_mode = 2;
        end else begin
          m_cur.push_back(d);
        end
      end else if (m_mode == 2 && d == 8'h00) begin
        m_mode = 0;
      end
    end
    if (commit) begin
      m_disp = m_cur;
      m_have = 1; m_pos = 0; m_elapsed = 0;
    end else if (m_have && !cur_freeze) begin
      lim = (cur_dwell == 0) ? 1 : cur_dwell;
      if (m_elapsed + 1 >= lim) begin
        m_elapsed = 0;
        m_pos = (m_pos + 1) % m_disp.size();
      end else begin
        m_elapsed++;
      end
    end
  endfunction

  // One clock of stimulus, issued from a falling edge
  task automatic step(input logic [7:0] d, input bit v);
    reset        = 1'b0;
    data_in      = d;
    data_valid   = v;
    dwell_cycles = WW'(cur_dwell);
    freeze       = cur_freeze;
    model_edge(d, v);
    exp_q.push_back(model_out());
    @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d);
    step(d, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'($urandom), 1'b0);
  endtask

  task automatic send_payload(input int n);
    for (int i = 0; i < n; i++) send(8'($urandom_range(1, 127)));
  endtask

  task automatic hold_reset_cycle();
    model_reset();
    exp_q.push_back(model_out());
    @(negedge clock);
  endtask

  // Async reset between edges: one check right after it rises, one at the edge
  task automatic reset_mid();
    #2;
    model_reset();
    exp_q.push_back(model_out());
    exp_q.push_back(model_out());
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Monitor: compare on every rising clock edge and on every reset assertion
  initial begin
    exp_t e;
    exp_t got;
    #1;
    forever begin
      @(posedge clock or posedge reset);
      #1;
      got = {data_shown, byte_idx, frame_len, frame_ready, capturing, overflow};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL no_expectation t=%0t got=%h", $time, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t shown/idx/len/rdy/cap/ovf got=%h/%0d/%0d/%b/%b/%b req=%h/%0d/%0d/%b/%b/%b",
                   $time, got.shown, got.idx, got.len, got.ready, got.capt, got.ovf,
                   e.shown, e.idx, e.len, e.ready, e.capt, e.ovf);
        end
      end
    end
  end

  initial begin
    int r;
    logic [7:0] d;
    model_reset();
    hold_reset_cycle();
    hold_reset_cycle();

    // Basic frame, dwell 4
    cur_dwell = 4;
    send(8'h9C); send(8'h01); send(8'h02); send(8'h00);
    idle(14);

    // Full depth
    cur_dwell = 2;
    send(8'h80); send_payload(8); send(8'h00);
    idle(22);

    // Overflow, trailing bytes discarded, then a normal frame
    send(8'h81); send_payload(10); send(8'h00);
    idle(4);
    send(8'h85); send(8'h11); send(8'h00);
    idle(8);

    // Resync and valid gaps
    send(8'h90); send(8'h05); send(8'hA0); send(8'h07); send(8'h00);
    idle(8);
    send(8'h8B); send(8'h01); idle(20); send(8'h02); send(8'h00);
    idle(8);

    // Freeze at index 1, then commit while frozen
    cur_dwell = 3;
    send(8'hC0); send(8'h01); send(8'h02); send(8'h03); send(8'h00);
    for (int i = 0; i < 40 && m_pos != 1; i++) idle(1);
    cur_freeze = 1'b1;
    idle(100);
    send(8'hD1); send(8'h44); send(8'h00);
    idle(10);
    cur_freeze = 1'b0;
    idle(10);

    // Reset mid-capture
    send(8'hE0); send(8'h12); send(8'h13);
    reset_mid();
    idle(3);
    // Single-byte frame and dwell 0
    cur_dwell = 0;
    send(8'hE5); send(8'h00);
    idle(3);
    send(8'hF0); send(8'h01); send(8'h02); send(8'h00);
    idle(10);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) cur_dwell = $urandom_range(0, 5);
      cur_freeze = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 99);
      if (r < 12)      d = 8'h80 | 8'($urandom_range(0, 127));
      else if (r < 24) d = 8'h00;
      else             d = 8'($urandom_range(1, 127));
      step(d, $urandom_range(0, 9) < 7);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
